pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  marks the corresponding source as actually read.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-009 mem_busy  in  1  data memory not ready; the MEM stage must hold.
REQ-010 pc_stall  out  1  holds the PC.
REQ-011 if_id_stall  out  1  drives the IF/ID register stall input.
REQ-012 if_id_flush  out  1  loads a bubble into IF/ID.
REQ-013 id_ex_stall / id_ex_flush  out  1 each  holds ID/EX / loads a bubble into ID/EX.
REQ-014 ex_mem_stall  out  1  holds EX/MEM.
REQ-015 pc_redirect  out  1  selects the branch target as next PC.
REQ-016 stall_count, flush_count  out  CNT_W each  performance counters.

Function
REQ-017 State machine SHALL have two states: RUN and MEM_WAIT; plus a 1-bit redirect_pending register.
REQ-018 All control outputs SHALL be combinational from state, redirect_pending and current inputs; zero-cycle latency.
REQ-019 Load-use hazard = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-020 Priority SHALL be mem_busy > redirect (ex_branch_taken or redirect_pending) > load-use.
REQ-021 RUN, mem_busy=1: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall; no flush, no redirect; next state MEM_WAIT; redirect_pending <= ex_branch_taken.
REQ-022 MEM_WAIT, mem_busy=1: same four stalls asserted; redirect_pending <= redirect_pending | ex_branch_taken.
REQ-023 MEM_WAIT, mem_busy=0: stalls deasserted; if redirect_pending | ex_branch_taken then redirect action; else load-use rule applies; next state RUN; redirect_pending <= 0.
REQ-024 Redirect action (RUN or exit of MEM_WAIT): pc_redirect=1, if_id_flush=1, id_ex_flush=1, all stalls 0; load-use ignored that cycle.
REQ-025 Load-use action: pc_stall=1, if_id_stall=1, id_ex_flush=1, id_ex_stall=0, ex_mem_stall=0; exactly one cycle per hazard occurrence.
REQ-026 No hazard: all outputs 0.
REQ-027 A stall and a flush SHALL never be asserted on the same register in the same cycle.
REQ-028 stall_count SHALL increment by 1 in every cycle pc_stall=1; flush_count SHALL increment by 1 in every cycle pc_redirect=1; both saturate at 2^CNT_W-1.

Reset
REQ-029 rst=1 at a clock edge SHALL set state RUN, redirect_pending 0, stall_count 0, flush_count 0.
REQ-030 While rst=1, if_id_flush=1 and id_ex_flush=1, all stall outputs 0, pc_redirect 0, counters not incremented.
REQ-031 rst asserted mid MEM_WAIT SHALL discard the pending redirect; first cycle after reset is RUN.

Verification
REQ-032 Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs1=5 -> one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_count 0->1.
REQ-033 Same with ex_rd=0 or id_rs1_used=0 -> all outputs 0.
REQ-034 ex_branch_taken=1 with concurrent load-use -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_count +1.
REQ-035 mem_busy=1 for 3 cycles, ex_branch_taken pulsed in cycle 2 only -> 3 cycles all four stalls, then one cycle redirect+flushes; stall_count +3, flush_count +1.
REQ-036 stall_count preset near max via 2^CNT_W cycles of mem_busy (CNT_W=4 build) -> holds at 15; rst=1 during MEM_WAIT with pending -> counters 0, no redirect after release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard and stall/flush control for a five-stage pipeline
// Outputs are combinational from state, redirect_pending and the current inputs.

module pipeline_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t state;
  logic   redirect_pending;
  logic   load_use;
  logic   redirect_req;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // redirect_pending is only ever set while in MEM_WAIT and cleared on exit,
  // so it can be OR-ed in unconditionally.
  assign redirect_req = ex_branch_taken || redirect_pending;

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    pc_redirect  = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (redirect_req) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state            <= MEM_WAIT;
            redirect_pending <= ex_branch_taken;
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            redirect_pending <= redirect_pending | ex_branch_taken;
          end else begin
            state            <= RUN;
            redirect_pending <= 1'b0;
          end
        end
        default: begin
          state            <= RUN;
          redirect_pending <= 1'b0;
        end
      endcase
    end
  end

  pipeline_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_count)
  );

  pipeline_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (CNT_W=4 build)

module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, pc_redirect}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_REDIR = 7'b0010101;
  localparam logic [6:0] O_STALL = 7'b1101010;
  localparam logic [6:0] O_RST   = 7'b0010100;

  typedef struct {
    string      name;
    logic [6:0] ctl;
    int         sc;
    int         fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, mem_busy;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, pc_redirect;
  logic [CNT_W-1:0] stall_count, flush_count;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .pc_redirect     (pc_redirect),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  task automatic drive(input string name, input logic r, input logic busy, input logic br,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [6:0] ctl, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_busy = busy; ex_branch_taken = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    e.name = name; e.ctl = ctl; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic idle(input string name, input int sc, input int fc);
    drive(name, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, O_NONE, sc, fc);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = sb.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, pc_redirect};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
      end
      total++;
      if ({28'd0, stall_count} !== e.sc || {28'd0, flush_count} !== e.fc) begin
        bad++;
        $display("FAIL %s counts: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                 e.name, stall_count, flush_count, e.sc, e.fc);
      end
      total++;
      if ((if_id_stall && if_id_flush) || (id_ex_stall && id_ex_flush)) begin
        bad++;
        $display("FAIL %s stall_and_flush: if_id=%b%b id_ex=%b%b", e.name,
                 if_id_stall, if_id_flush, id_ex_stall, id_ex_flush);
      end
    end
  end

  initial begin
    rst = 1'b1; mem_busy = 1'b0; ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;

    drive("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0);
    drive("reset1", 1, 1, 1, 1, 5, 5, 1, 0, 0, O_RST, 0, 0);
    idle("idle0", 0, 0);

    drive("lu_rs1", 0, 0, 0, 1, 5, 5, 1, 0, 0, O_LU, 0, 0);
    idle("after_lu_rs1", 1, 0);
    drive("lu_rd0", 0, 0, 0, 1, 0, 0, 1, 0, 0, O_NONE, 1, 0);
    drive("lu_unused", 0, 0, 0, 1, 5, 5, 0, 0, 0, O_NONE, 1, 0);
    drive("no_load", 0, 0, 0, 0, 5, 5, 1, 5, 1, O_NONE, 1, 0);
    drive("lu_rs2", 0, 0, 0, 1, 7, 3, 1, 7, 1, O_LU, 1, 0);
    idle("after_lu_rs2", 2, 0);

    drive("br_over_lu", 0, 0, 1, 1, 5, 5, 1, 0, 0, O_REDIR, 2, 0);
    idle("after_br", 2, 1);

    drive("busy_c1", 0, 1, 0, 0, 0, 0, 0, 0, 0, O_STALL, 2, 1);
    drive("busy_c2_br", 0, 1, 1, 1, 5, 5, 1, 0, 0, O_STALL, 3, 1);
    drive("busy_c3", 0, 1, 0, 0, 0, 0, 0, 0, 0, O_STALL, 4, 1);
    drive("wait_exit_redir", 0, 0, 0, 1, 5, 5, 1, 0, 0, O_REDIR, 5, 1);
    idle("after_wait_redir", 5, 2);

    drive("busy_lu", 0, 1, 0, 1, 4, 4, 1, 0, 0, O_STALL, 5, 2);
    drive("wait_exit_lu", 0, 0, 0, 1, 4, 4, 1, 0, 0, O_LU, 6, 2);
    idle("after_wait_lu", 7, 2);

    for (int i = 0; i < 16; i++)
      drive("sat_busy", 0, 1, 0, 0, 0, 0, 0, 0, 0, O_STALL, (7 + i > 15) ? 15 : 7 + i, 2);
    drive("sat_busy_br", 0, 1, 1, 0, 0, 0, 0, 0, 0, O_STALL, 15, 2);
    drive("rst_in_wait", 1, 1, 0, 0, 0, 0, 0, 0, 0, O_RST, 15, 2);
    drive("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0);
    idle("post_rst_no_redir", 0, 0);
    idle("post_rst_idle", 0, 0);

    drive("run_busy_br", 0, 1, 1, 0, 0, 0, 0, 0, 0, O_STALL, 0, 0);
    idle("run_busy_br_exit", 1, 0);
    sb[sb.size()-1].ctl = O_REDIR;
    idle("final", 1, 1);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    done = 1'b1;
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
    end
  end

endmodule
